// File: rtl/stopwatch_pkg.sv
// Shared definitions for the multi-channel stopwatch controller.
// The state encoding is visible on the top-level state port, so it is fixed here.
package stopwatch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    STAT_IDLE = 2'b00,
    STAT_RUN  = 2'b01,
    STAT_STOP = 2'b10,
    STAT_LAP  = 2'b11
  } stat_e;

  typedef struct packed {
    logic ss;
    logic lap;
    logic clr;
  } btn_t;

  // The counter advances in both RUN and LAP; only the display differs.
  function automatic logic is_running(input stat_e s);
    return (s == STAT_RUN) || (s == STAT_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_chan.sv
// One stopwatch channel: button edge detect, start/stop/lap/clear FSM,
// saturating elapsed counter with sticky overflow, and lap display latch.
module stopwatch_chan
  import stopwatch_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  input  logic               ss_i,
  input  logic               lap_i,
  input  logic               clr_i,
  output logic               en_o,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  btn_t             btn_q;
  btn_t             press;
  stat_e            state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lap_q, lap_d;
  logic             ovf_q, ovf_d;

  // btn_q clears on reset, so a button held through reset release counts as a press.
  assign press.ss  = ss_i  & ~btn_q.ss;
  assign press.lap = lap_i & ~btn_q.lap;
  assign press.clr = clr_i & ~btn_q.clr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_q   <= '0;
      state_q <= STAT_IDLE;
      cnt_q   <= '0;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      btn_q.ss  <= ss_i;
      btn_q.lap <= lap_i;
      btn_q.clr <= clr_i;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lap_q     <= lap_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;

    // Counting follows the registered state, so the edge entering RUN does
    // not count and the edge leaving RUN/LAP for STOP does.
    if (tick_i && is_running(state_q)) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      STAT_IDLE: begin
        if (press.ss) state_d = STAT_RUN;
      end
      STAT_RUN: begin
        if (press.ss) begin
          state_d = STAT_STOP;
        end else if (press.lap) begin
          state_d = STAT_LAP;
          lap_d   = cnt_q;
        end
      end
      STAT_LAP: begin
        if      (press.ss)  state_d = STAT_STOP;
        else if (press.lap) state_d = STAT_RUN;
      end
      STAT_STOP: begin
        if (press.clr) begin
          state_d = STAT_IDLE;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (press.ss) begin
          state_d = STAT_RUN;
        end
      end
      default: state_d = STAT_IDLE;
    endcase
  end

  assign en_o    = is_running(state_q);
  assign state_o = state_q;
  assign count_o = (state_q == STAT_LAP) ? lap_q : cnt_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Multi-channel stopwatch controller: CH independent channels sharing only the
// timebase tick, with outputs packed channel-major onto flat buses.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CH    = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [CH-1:0]         start_stop,
  input  logic [CH-1:0]         lap,
  input  logic [CH-1:0]         clr,
  output logic [CH-1:0]         en,
  output logic [STATE_W*CH-1:0] state,
  output logic [CH*CNT_W-1:0]   count,
  output logic [CH-1:0]         ovf
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    stopwatch_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk_i   (clk),
      .rst_i   (rst),
      .tick_i  (tick),
      .ss_i    (start_stop[i]),
      .lap_i   (lap[i]),
      .clr_i   (clr[i]),
      .en_o    (en[i]),
      .state_o (state[STATE_W*i +: STATE_W]),
      .count_o (count[CNT_W*i +: CNT_W]),
      .ovf_o   (ovf[i])
    );
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboarded bench for stopwatch_ctrl: directed scenarios then random buttons,
// checked against a behavioural per-channel stopwatch model.
module tb_stopwatch_ctrl;

  localparam int CH    = 3;
  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << CNT_W) - 1;
  localparam int S_IDLE = 0, S_RUN = 1, S_STOP = 2, S_LAP = 3;

  logic                clk = 1'b0;
  logic                rst, tick;
  logic [CH-1:0]       start_stop, lap, clr;
  logic [CH-1:0]       en;
  logic [2*CH-1:0]     state;
  logic [CH*CNT_W-1:0] count;
  logic [CH-1:0]       ovf;

  stopwatch_ctrl #(.CH(CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .lap(lap),
    .clr(clr), .en(en), .state(state), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*CH-1:0]     st;
    logic [CH-1:0]       en;
    logic [CH*CNT_W-1:0] cnt;
    logic [CH-1:0]       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;

  // Behavioural model: a stopwatch per channel tracked in plain integers.
  int m_st[CH], m_time[CH], m_shown_lap[CH];
  bit m_ovf[CH], m_prev_ss[CH], m_prev_lap[CH], m_prev_clr[CH];

  task automatic model_step(input bit r, input bit t, input bit [CH-1:0] s,
                            input bit [CH-1:0] l, input bit [CH-1:0] c);
    for (int i = 0; i < CH; i++) begin
      bit ps, pl, pc, timing;
      if (r) begin
        m_st[i] = S_IDLE; m_time[i] = 0; m_shown_lap[i] = 0; m_ovf[i] = 0;
        m_prev_ss[i] = 0; m_prev_lap[i] = 0; m_prev_clr[i] = 0;
        continue;
      end
      ps = s[i] && !m_prev_ss[i];
      pl = l[i] && !m_prev_lap[i];
      pc = c[i] && !m_prev_clr[i];
      timing = (m_st[i] == S_RUN) || (m_st[i] == S_LAP);
      if (m_st[i] == S_RUN && !ps && pl) m_shown_lap[i] = m_time[i];
      if (t && timing) begin
        if (m_time[i] == MAXV) m_ovf[i] = 1;
        else m_time[i] = m_time[i] + 1;
      end
      if (m_st[i] == S_IDLE) begin
        if (ps) m_st[i] = S_RUN;
      end else if (m_st[i] == S_RUN) begin
        if (ps) m_st[i] = S_STOP;
        else if (pl) m_st[i] = S_LAP;
      end else if (m_st[i] == S_LAP) begin
        if (ps) m_st[i] = S_STOP;
        else if (pl) m_st[i] = S_RUN;
      end else begin
        if (pc) begin m_st[i] = S_IDLE; m_time[i] = 0; m_ovf[i] = 0; end
        else if (ps) m_st[i] = S_RUN;
      end
      m_prev_ss[i] = s[i]; m_prev_lap[i] = l[i]; m_prev_clr[i] = c[i];
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      e.st[2*i +: 2]       = 2'(m_st[i]);
      e.en[i]              = (m_st[i] == S_RUN) || (m_st[i] == S_LAP);
      e.cnt[CNT_W*i +: CNT_W] = CNT_W'((m_st[i] == S_LAP) ? m_shown_lap[i] : m_time[i]);
      e.ovf[i]             = m_ovf[i];
    end
    return e;
  endfunction

  // One call = one rising edge of stimulus; expectation queued for the monitor.
  task automatic apply(input bit r, input bit t, input bit [CH-1:0] s,
                       input bit [CH-1:0] l, input bit [CH-1:0] c);
    rst = r; tick = t; start_stop = s; lap = l; clr = c;
    model_step(r, t, s, l, c);
    sb_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_empty at cycle %0d: got 0 entries, expected 1", cycle);
      end else begin
        e = sb_q.pop_front();
        chk("state", 64'(state), 64'(e.st));
        chk("en",    64'(en),    64'(e.en));
        chk("count", 64'(count), 64'(e.cnt));
        chk("ovf",   64'(ovf),   64'(e.ovf));
      end
    end
  end

  initial begin : driver
    apply(1, 1, 0, 0, 0);
    apply(1, 1, 0, 0, 0);
    repeat (20) apply(0, 1, 0, 0, 0);
    // ch0 start, 10 ticks, stop -> STOP with 10
    apply(0, 1, 'h1, 0, 0);
    repeat (10) apply(0, 1, 0, 0, 0);
    apply(0, 0, 'h1, 0, 0);
    repeat (3) apply(0, 1, 0, 0, 0);
    // clr beats start_stop in STOP
    apply(0, 1, 'h1, 0, 'h1);
    apply(0, 1, 0, 0, 0);
    // lap at 5, 7 more ticks, unlap shows 12
    apply(0, 0, 'h1, 0, 0);
    repeat (5) apply(0, 1, 0, 0, 0);
    apply(0, 0, 0, 'h1, 0);
    repeat (7) apply(0, 1, 0, 0, 0);
    apply(0, 0, 0, 'h1, 0);
    apply(0, 0, 0, 0, 0);
    // clr ignored while running
    apply(0, 1, 0, 0, 'h1);
    apply(0, 1, 0, 0, 0);
    apply(0, 0, 'h1, 0, 0);
    // ch1 saturation then clear
    apply(0, 0, 'h2, 0, 0);
    repeat (20) apply(0, 1, 0, 0, 0);
    apply(0, 1, 'h2, 0, 0);
    apply(0, 1, 0, 0, 0);
    apply(0, 1, 0, 0, 'h2);
    apply(0, 1, 0, 0, 0);
    // held button through reset release, then reset mid-run
    repeat (3) apply(1, 1, 'h1, 0, 0);
    repeat (5) apply(0, 1, 'h1, 0, 0);
    repeat (3) apply(0, 1, 0, 0, 0);
    apply(1, 1, 0, 0, 0);
    repeat (2) apply(0, 1, 0, 0, 0);
    // random button activity
    for (int n = 0; n < 3000; n++) begin
      bit [CH-1:0] s, l, c;
      for (int i = 0; i < CH; i++) begin
        s[i] = ($urandom % 5) == 0;
        l[i] = ($urandom % 6) == 0;
        c[i] = ($urandom % 6) == 0;
      end
      apply(($urandom % 400) == 0, ($urandom % 3) != 0, s, l, c);
    end
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
